// File: rtl/reg_file_banked_pkg.sv
// Shared types and constants for the banked register file and its bank controller.
package reg_file_banked_pkg;

    localparam int unsigned NREGS     = 16;
    localparam int unsigned BANK_BASE = 12;

    typedef logic [3:0] reg_addr_t;

    typedef enum logic {
        BANK_MAIN = 1'b0,
        BANK_IRQ  = 1'b1
    } bank_t;

endpackage

// File: rtl/reg_file_banked_bank.sv
// MAIN/IRQ bank state machine with a registered one-cycle error pulse on illegal strobes.
module bank_ctrl
    import reg_file_banked_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq_enter,
    input  logic irq_return,
    output logic bank,
    output logic bank_err
);

    bank_t state_q, state_d;
    logic  err_q, err_d;

    // Next bank and error decision; any illegal or simultaneous strobe holds the bank.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            BANK_MAIN: begin
                if (irq_enter && !irq_return) begin
                    state_d = BANK_IRQ;
                end else if (irq_return) begin
                    err_d = 1'b1;
                end
            end
            BANK_IRQ: begin
                if (irq_return && !irq_enter) begin
                    state_d = BANK_MAIN;
                end else if (irq_enter) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = BANK_MAIN;
            end
        endcase
    end

    // State and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BANK_MAIN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign bank     = state_q;
    assign bank_err = err_q;

endmodule

// File: rtl/reg_file_banked.sv
// Register file with R12..R15 banked between main and interrupt contexts; R0 reads as zero.
module reg_file_banked
    import reg_file_banked_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NREGS     = reg_file_banked_pkg::NREGS,
    parameter int unsigned BANK_BASE = reg_file_banked_pkg::BANK_BASE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] rs1_addr,
    input  logic [$clog2(NREGS)-1:0] rs2_addr,
    output logic [WIDTH-1:0]         rs1_data,
    output logic [WIDTH-1:0]         rs2_data,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    input  logic [WIDTH-1:0]         rd_data,
    input  logic                     irq_enter,
    input  logic                     irq_return,
    output logic                     bank,
    output logic                     bank_err
);

    localparam int unsigned AW      = $clog2(NREGS);
    localparam int unsigned NBANKED = NREGS - BANK_BASE;
    localparam int unsigned BW      = (NBANKED > 1) ? $clog2(NBANKED) : 1;

    // R0 has no storage; common entries start at R1.
    logic [WIDTH-1:0] common_q [1:BANK_BASE-1];
    logic [WIDTH-1:0] banked_q [2][NBANKED];

    logic          cur_bank;
    logic [AW-1:0] rs1_off, rs2_off, rd_off;

    bank_ctrl u_bank_ctrl (
        .clk        (clk),
        .rst        (rst),
        .irq_enter  (irq_enter),
        .irq_return (irq_return),
        .bank       (cur_bank),
        .bank_err   (bank_err)
    );

    assign bank    = cur_bank;
    assign rs1_off = rs1_addr - AW'(BANK_BASE);
    assign rs2_off = rs2_addr - AW'(BANK_BASE);
    assign rd_off  = rd_addr - AW'(BANK_BASE);

    // Combinational read ports; no bypass from the write port.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr >= AW'(BANK_BASE)) begin
            rs1_data = banked_q[cur_bank][rs1_off[BW-1:0]];
        end else if (rs1_addr != '0) begin
            rs1_data = common_q[rs1_addr];
        end
        if (rs2_addr >= AW'(BANK_BASE)) begin
            rs2_data = banked_q[cur_bank][rs2_off[BW-1:0]];
        end else if (rs2_addr != '0) begin
            rs2_data = common_q[rs2_addr];
        end
    end

    // Write port; uses the pre-edge bank so a write during a switch lands in the outgoing bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < int'(BANK_BASE); i++) begin
                common_q[i] <= '0;
            end
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(NBANKED); i++) begin
                    banked_q[b][i] <= '0;
                end
            end
        end else if (we && rd_addr != '0) begin
            if (rd_addr >= AW'(BANK_BASE)) begin
                banked_q[cur_bank][rd_off[BW-1:0]] <= rd_data;
            end else begin
                common_q[rd_addr] <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_banked.sv
// Randomized and directed bench for reg_file_banked with a queue-based scoreboard.
module tb_reg_file_banked;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic [15:0] rs1_data, rs2_data, rd_data = '0;
    logic        we = 1'b0, irq_enter = 1'b0, irq_return = 1'b0;
    logic        bank, bank_err;

    reg_file_banked dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .we         (we),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .irq_enter  (irq_enter),
        .irq_return (irq_return),
        .bank       (bank),
        .bank_err   (bank_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r1;
        logic [15:0] r2;
        logic        b;
        logic        e;
        int          n;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int errors = 0;
    int step_n = 0;

    // Reference model: architectural view of the register file.
    logic [15:0] m_common [16];
    logic [15:0] m_banked [2][16];
    bit          m_bank = 1'b0;
    bit          m_err  = 1'b0;
    bit          m_known = 1'b0;

    function automatic logic [15:0] m_read(input logic [3:0] a);
        if (a == 4'd0) return 16'h0000;
        if (a >= 4'd12) return m_banked[m_bank][a];
        return m_common[a];
    endfunction

    task automatic chk(input string name, input int n, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [3:0] rd, input logic [15:0] d,
                        input logic [3:0] a1, input logic [3:0] a2, input bit en, input bit rt);
        exp_t e;
        bit   err_next;
        @(posedge clk);
        #1;
        rst = r; we = w; rd_addr = rd; rd_data = d;
        rs1_addr = a1; rs2_addr = a2; irq_enter = en; irq_return = rt;
        step_n++;
        if (m_known) begin
            e.r1 = m_read(a1);
            e.r2 = m_read(a2);
            e.b  = m_bank;
            e.e  = m_err;
            e.n  = step_n;
            expq.push_back(e);
        end
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                m_common[i] = '0;
                m_banked[0][i] = '0;
                m_banked[1][i] = '0;
            end
            m_bank = 1'b0;
            m_err = 1'b0;
            m_known = 1'b1;
        end else begin
            if (w && rd != 4'd0) begin
                if (rd >= 4'd12) m_banked[m_bank][rd] = d;
                else m_common[rd] = d;
            end
            err_next = (en && rt) || (en && m_bank) || (rt && !m_bank);
            m_err = err_next;
            if (!err_next) begin
                if (en) m_bank = 1'b1;
                if (rt) m_bank = 1'b0;
            end
        end
    endtask

    task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
        step(0, 0, 4'd0, 16'h0, a1, a2, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rs1_data", e.n, rs1_data, e.r1);
                chk("rs2_data", e.n, rs2_data, e.r2);
                chk("bank", e.n, {15'h0, bank}, {15'h0, e.b});
                chk("bank_err", e.n, {15'h0, bank_err}, {15'h0, e.e});
            end
        end
    end

    initial begin
        step(1, 0, 4'd0, 16'h0, 4'd0, 4'd0, 0, 0);
        for (int i = 0; i < 16; i++) idle(4'(i), 4'(15 - i));

        // R0 discard, no bypass
        step(0, 1, 4'd0, 16'hBEEF, 4'd0, 4'd0, 0, 0);
        idle(4'd0, 4'd0);
        step(0, 1, 4'd5, 16'h1234, 4'd5, 4'd0, 0, 0);
        idle(4'd5, 4'd5);

        // Bank isolation
        step(0, 1, 4'd13, 16'hAAAA, 4'd13, 4'd3, 0, 0);
        step(0, 1, 4'd3, 16'h0303, 4'd13, 4'd3, 0, 0);
        step(0, 0, 4'd0, 16'h0, 4'd13, 4'd3, 1, 0);
        step(0, 1, 4'd13, 16'h5555, 4'd13, 4'd3, 0, 0);
        idle(4'd13, 4'd3);
        step(0, 0, 4'd0, 16'h0, 4'd13, 4'd3, 0, 1);
        idle(4'd13, 4'd3);

        // Write during switch lands in outgoing bank
        step(0, 1, 4'd14, 16'h0E0E, 4'd14, 4'd13, 1, 0);
        idle(4'd14, 4'd13);
        step(0, 0, 4'd0, 16'h0, 4'd14, 4'd13, 0, 1);
        idle(4'd14, 4'd13);

        // Error strobes
        step(0, 0, 4'd0, 16'h0, 4'd1, 4'd2, 0, 1);
        idle(4'd1, 4'd2);
        step(0, 0, 4'd0, 16'h0, 4'd1, 4'd2, 1, 0);
        step(0, 0, 4'd0, 16'h0, 4'd1, 4'd2, 1, 0);
        idle(4'd1, 4'd2);
        idle(4'd1, 4'd2);
        step(0, 0, 4'd0, 16'h0, 4'd1, 4'd2, 1, 1);
        idle(4'd1, 4'd2);
        step(0, 0, 4'd0, 16'h0, 4'd1, 4'd2, 0, 1);
        step(0, 0, 4'd0, 16'h0, 4'd1, 4'd2, 1, 1);
        idle(4'd1, 4'd2);

        // Reset mid-handler
        step(0, 0, 4'd0, 16'h0, 4'd15, 4'd5, 1, 0);
        step(0, 1, 4'd15, 16'h7777, 4'd15, 4'd5, 0, 0);
        step(1, 1, 4'd15, 16'h1111, 4'd15, 4'd5, 1, 0);
        for (int i = 0; i < 16; i++) idle(4'(i), 4'(15 - i));
        step(0, 0, 4'd0, 16'h0, 4'd15, 4'd14, 1, 0);
        for (int i = 0; i < 16; i++) idle(4'(i), 4'(15 - i));
        step(0, 0, 4'd0, 16'h0, 4'd15, 4'd14, 0, 1);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), 16'($urandom),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        repeat (3) @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
